// File: rtl/dt_traverse_ctrl.sv
// Decision-tree traversal sequencer: arbitrates host table loads against inference walks
// and steps the node-RAM / MAC datapath from root to leaf.
module dt_traverse_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned MAC_LAT    = 2,
    parameter int unsigned MAX_DEPTH  = 16,
    parameter int unsigned ROOT_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [29:0]           in_attr,
    output logic [29:0]           attr_out,
    input  logic                  ld_req,
    input  logic                  ld_sel,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  ld_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  we1,
    output logic                  we2,
    input  logic [9:0]            node_thresh,
    input  logic [17:0]           child_word,
    input  logic [15:0]           mac_acc,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            out_class,
    output logic                  depth_err
);

    localparam int unsigned ATTR_W  = 30;
    localparam int unsigned CLS_W   = 8;
    localparam int unsigned DEPTH_W = 8;
    localparam int unsigned CNT_W   = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] FETCH  = 3'd2;
    localparam logic [2:0] MAC    = 3'd3;
    localparam logic [2:0] DECIDE = 3'd4;

    logic [2:0]            state, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic                  we1_d, we2_d, busy_d, done_d, depth_err_d, ld_ready_d;
    logic [CLS_W-1:0]      out_class_d;
    logic [ATTR_W-1:0]     attr_d;
    logic                  start_pending, pend_d;
    logic [DEPTH_W-1:0]    depth, depth_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic                  go_left_c;
    logic [8:0]            sel_c;

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mem_addr      <= ADDR_WIDTH'(ROOT_ADDR);
            we1           <= 1'b0;
            we2           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            depth_err     <= 1'b0;
            out_class     <= '0;
            attr_out      <= '0;
            ld_ready      <= 1'b1;
            start_pending <= 1'b0;
            depth         <= '0;
            cnt           <= '0;
        end else begin
            state         <= state_d;
            mem_addr      <= mem_addr_d;
            we1           <= we1_d;
            we2           <= we2_d;
            busy          <= busy_d;
            done          <= done_d;
            depth_err     <= depth_err_d;
            out_class     <= out_class_d;
            attr_out      <= attr_d;
            ld_ready      <= ld_ready_d;
            start_pending <= pend_d;
            depth         <= depth_d;
            cnt           <= cnt_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        mem_addr_d  = mem_addr;
        we1_d       = 1'b0;
        we2_d       = 1'b0;
        busy_d      = busy;
        done_d      = 1'b0;
        depth_err_d = depth_err;
        out_class_d = out_class;
        attr_d      = attr_out;
        ld_ready_d  = ld_ready;
        pend_d      = start_pending;
        depth_d     = depth;
        cnt_d       = cnt;

        // Unsigned compare; equality takes the left child
        go_left_c = (mac_acc <= {6'b0, node_thresh});
        sel_c     = go_left_c ? child_word[17:9] : child_word[8:0];

        case (state)
            IDLE: begin
                ld_ready_d = 1'b1;
                if (ld_req && ld_ready) begin
                    state_d    = LOAD;
                    mem_addr_d = ld_addr;
                    we1_d      = ~ld_sel;
                    we2_d      = ld_sel;
                    ld_ready_d = 1'b0;
                    if (start) begin
                        attr_d = in_attr;
                        pend_d = 1'b1;
                    end
                end else if (start) begin
                    state_d     = FETCH;
                    attr_d      = in_attr;
                    mem_addr_d  = ADDR_WIDTH'(ROOT_ADDR);
                    depth_d     = '0;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    depth_err_d = 1'b0;
                    ld_ready_d  = 1'b0;
                end
            end
            LOAD: begin
                if (start_pending) begin
                    pend_d      = 1'b0;
                    state_d     = FETCH;
                    mem_addr_d  = ADDR_WIDTH'(ROOT_ADDR);
                    depth_d     = '0;
                    cnt_d       = '0;
                    busy_d      = 1'b1;
                    depth_err_d = 1'b0;
                    ld_ready_d  = 1'b0;
                end else begin
                    state_d    = IDLE;
                    ld_ready_d = 1'b1;
                end
            end
            FETCH: begin
                if (cnt == CNT_W'(MEM_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = MAC;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            MAC: begin
                if (cnt == CNT_W'(MAC_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = DECIDE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DECIDE: begin
                if (sel_c[8]) begin
                    out_class_d = sel_c[7:0];
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    ld_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else if ((9'(depth) + 9'd1) == 9'(MAX_DEPTH)) begin
                    depth_err_d = 1'b1;
                    out_class_d = '0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    ld_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    depth_d    = depth + DEPTH_W'(1);
                    mem_addr_d = ADDR_WIDTH'(sel_c[7:0]);
                    cnt_d      = '0;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                ld_ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_dt_traverse_ctrl.sv
// Scoreboard bench for dt_traverse_ctrl: node RAMs and MAC are modelled as address-indexed
// tables; expected done results and host writes are queued and checked by monitors.
module tb_dt_traverse_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [29:0] in_attr;
    logic [29:0] attr_out;
    logic        ld_req, ld_sel;
    logic [7:0]  ld_addr;
    logic        ld_ready;
    logic [7:0]  mem_addr;
    logic        we1, we2;
    logic [9:0]  node_thresh;
    logic [17:0] child_word;
    logic [15:0] mac_acc;
    logic        busy, done;
    logic [7:0]  out_class;
    logic        depth_err;

    logic [9:0]  thr_mem   [0:255];
    logic [17:0] child_mem [0:255];
    logic [15:0] acc_mem   [0:255];

    assign node_thresh = thr_mem[mem_addr];
    assign child_word  = child_mem[mem_addr];
    assign mac_acc     = acc_mem[mem_addr];

    typedef struct {
        logic [7:0] cls;
        logic       err;
        int         lat;
    } done_exp_t;

    typedef struct {
        logic       sel;
        logic [7:0] addr;
    } wr_exp_t;

    done_exp_t exp_q[$];
    wr_exp_t   wr_q[$];
    logic [7:0] trace[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    int last_done_cyc = 0;
    int last_wr_cyc = 0;

    dt_traverse_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .in_attr(in_attr), .attr_out(attr_out),
        .ld_req(ld_req), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_ready(ld_ready),
        .mem_addr(mem_addr), .we1(we1), .we2(we2), .node_thresh(node_thresh),
        .child_word(child_word), .mac_acc(mac_acc), .busy(busy), .done(done),
        .out_class(out_class), .depth_err(depth_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Done monitor
    always @(negedge clk) begin
        done_exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done class 0x%0h expected no done", out_class);
            end else begin
                e = exp_q.pop_front();
                chk("done_class", 32'(out_class), 32'(e.cls));
                chk("done_err", 32'(depth_err), 32'(e.err));
                chk("done_latency", 32'(cyc - t_start), 32'(e.lat));
                chk("done_busy", 32'(busy), 32'd0);
            end
            last_done_cyc = cyc;
        end
    end

    // Write monitor
    always @(negedge clk) begin
        wr_exp_t w;
        if (!rst && (we1 || we2)) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got we1=%0b we2=%0b addr=0x%0h expected none", we1, we2, mem_addr);
            end else begin
                w = wr_q.pop_front();
                chk("wr_we2", 32'(we2), 32'(w.sel));
                chk("wr_we1", 32'(we1), 32'(!w.sel));
                chk("wr_addr", 32'(mem_addr), 32'(w.addr));
                chk("wr_not_busy", 32'(busy), 32'd0);
            end
            last_wr_cyc = cyc;
        end
    end

    // Address trace while busy
    always @(negedge clk) begin
        if (!rst && busy && (trace.size() == 0 || trace[$] != mem_addr))
            trace.push_back(mem_addr);
    end

    task automatic start_run(input logic [29:0] attr, input logic [7:0] cls, input logic err,
                             input int lat);
        done_exp_t e;
        @(negedge clk);
        trace.delete();
        in_attr = attr;
        start   = 1'b1;
        e.cls = cls; e.err = err; e.lat = lat;
        exp_q.push_back(e);
        @(negedge clk);
        start   = 1'b0;
        t_start = cyc;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d done / %0d writes pending expected 0", exp_q.size(), wr_q.size());
            exp_q.delete();
            wr_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_we"}, 32'({we1, we2}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_depth_err"}, 32'(depth_err), 32'd0);
        chk({tag, "_out_class"}, 32'(out_class), 32'd0);
        chk({tag, "_attr_out"}, 32'(attr_out), 32'd0);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
    endtask

    initial begin
        wr_exp_t w;
        for (int i = 0; i < 256; i++) begin
            thr_mem[i]   = '0;
            child_mem[i] = {9'h100, 9'h100};
            acc_mem[i]   = '0;
        end
        rst = 1'b1; start = 1'b0; in_attr = '0;
        ld_req = 1'b0; ld_sel = 1'b0; ld_addr = '0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Root leaf, equality goes left, then one above goes right
        child_mem[0] = {9'h103, 9'h104};
        thr_mem[0]   = 10'd100;
        acc_mem[0]   = 16'd100;
        start_run(30'h1234567, 8'h03, 1'b0, 4);
        wait_idle();
        acc_mem[0] = 16'd101;
        start_run(30'h0ABCDEF, 8'h04, 1'b0, 4);
        wait_idle();
        chk("attr_latched", 32'(attr_out), 32'h0ABCDEF);

        // Two-level walk: 0 left -> 7, 7 right -> leaf 0x2A
        child_mem[0] = {9'h007, 9'h1FF}; thr_mem[0] = 10'd50; acc_mem[0] = 16'd50;
        child_mem[7] = {9'h111, 9'h12A}; thr_mem[7] = 10'd10; acc_mem[7] = 16'd11;
        start_run(30'h2AAAAAA, 8'h2A, 1'b0, 8);
        wait_idle();
        chk("trace_len", 32'(trace.size()), 32'd2);
        if (trace.size() == 2) begin
            chk("trace_0", 32'(trace[0]), 32'd0);
            chk("trace_1", 32'(trace[1]), 32'd7);
        end

        // Self-loop trips the depth guard after 16 decisions
        child_mem[0] = {9'h000, 9'h000}; thr_mem[0] = 10'd100; acc_mem[0] = 16'd0;
        start_run(30'h1, 8'h00, 1'b1, 64);
        wait_idle();
        chk("depth_err_sticky", 32'(depth_err), 32'd1);
        child_mem[0] = {9'h103, 9'h104}; acc_mem[0] = 16'd100;
        start_run(30'h2, 8'h03, 1'b0, 4);
        chk("depth_err_cleared", 32'(depth_err), 32'd0);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_idle();

        // start and ld_req together: load first, then pending traversal
        @(negedge clk);
        trace.delete();
        in_attr = 30'h3C3C3C3; start = 1'b1;
        ld_req = 1'b1; ld_sel = 1'b1; ld_addr = 8'd9;
        w.sel = 1'b1; w.addr = 8'd9;
        wr_q.push_back(w);
        begin
            done_exp_t e;
            e.cls = 8'h03; e.err = 1'b0; e.lat = 5;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0; ld_req = 1'b0; in_attr = 30'h0000111;
        t_start = cyc;
        chk("load_ld_ready", 32'(ld_ready), 32'd0);
        wait_idle();
        chk("arb_attr", 32'(attr_out), 32'h3C3C3C3);
        chk("arb_trace_root", 32'(trace.size() > 0 ? trace[0] : 8'hFF), 32'd0);

        // ld_req during busy is held off until the walk completes
        acc_mem[0] = 16'd101;
        start_run(30'h5, 8'h04, 1'b0, 4);
        ld_req = 1'b1; ld_sel = 1'b0; ld_addr = 8'h33;
        w.sel = 1'b0; w.addr = 8'h33;
        wr_q.push_back(w);
        for (int i = 0; i < 2; i++) begin
            chk("busy_ld_ready", 32'(ld_ready), 32'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 50; i++) begin
            if (we1 || we2) break;
            @(negedge clk);
        end
        ld_req = 1'b0;
        wait_idle();
        chk("wr_after_done", 32'(last_wr_cyc), 32'(last_done_cyc + 1));

        // start while busy is ignored
        start_run(30'h0AAAA, 8'h04, 1'b0, 4);
        in_attr = 30'h0BBBB; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (8) @(negedge clk);
        chk("ignored_attr", 32'(attr_out), 32'h0AAAA);

        // Reset while in MAC at node 5, then a clean restart
        child_mem[0] = {9'h005, 9'h005}; acc_mem[0] = 16'd0;
        child_mem[5] = {9'h101, 9'h101};
        start_run(30'h777, 8'h01, 1'b0, 8);
        repeat (5) @(negedge clk);
        chk("pre_rst_addr", 32'(mem_addr), 32'd5);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk_reset_vals("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        start_run(30'h888, 8'h01, 1'b0, 8);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

endmodule
